// File: rtl/mmio_trace_pkg.sv
// mmio_trace_pkg: shared widths and sizing helpers for the MMIO write tracer
//   ADDR_W/DATA_W/MASK_W : fixed mmio bus field widths
//   win_w()              : window-index width, clog2(n) with a minimum of 1
//   entry_w()            : packed trace entry width {ts, addr, data, mask, win}
package mmio_trace_pkg;
   localparam int ADDR_W = 30;
   localparam int DATA_W = 32;
   localparam int MASK_W = 4;
   function automatic int win_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic int entry_w(input int ts_w, input int ww);
      return ts_w + ADDR_W + DATA_W + MASK_W + ww;
   endfunction
endpackage

// File: rtl/mmio_trace_fifo.sv
// mmio_trace_fifo: synchronous FIFO with head presented from the storage flops
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   i_push     : enqueue i_data (ignored when full unless popping the same cycle)
//   i_pop      : dequeue head (ignored when empty)
//   o_valid    : head valid, o_full : no free slot, o_data : head entry (0 when empty)
module mmio_trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   output logic             o_full,
   output logic [WIDTH-1:0] o_data
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr, r_rd;
   logic             w_empty, w_pop, w_push;
   assign w_empty = r_wr == r_rd;
   // extra pointer bit distinguishes full from empty when the indices coincide
   assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_pop   = i_pop && !w_empty;
   // a pop frees the head slot this edge, so a push while full still fits
   assign w_push  = i_push && (!o_full || w_pop);
   assign o_valid = !w_empty;
   assign o_data  = w_empty ? '0 : r_mem[r_rd[AW-1:0]];
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
      end
   end
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
endmodule

// File: rtl/mmio_trace_monitor.sv
// mmio_trace_monitor: MMIO write tracer with address windows, timestamps, trace FIFO and end-of-run flags
//   clk, rst_n                        : clock, synchronous active-low reset
//   i_mmio_addr/data/mask/wren        : observed cpu write bus
//   i_win_en/lo/hi                    : per-window enable and inclusive bounds (30 bits per window)
//   o_trace_valid, i_trace_ready      : FIFO head handshake
//   o_trace_ts/addr/data/mask/win     : FIFO head entry
//   o_drop_cnt                        : saturating count of matched writes lost to a full FIFO
//   o_halt, o_halt_code, o_timeout    : sticky end-of-run flags and halt write data
module mmio_trace_monitor
   import mmio_trace_pkg::*;
#(
   parameter int          N_WIN       = 2,
   parameter int          DEPTH       = 16,
   parameter int          TS_W        = 32,
   parameter int          DROP_W      = 16,
   parameter logic [29:0] HALT_ADDR   = 30'h3FFFFFFF,
   parameter int          TIMEOUT_CYC = 7500,
   localparam int         WIN_W       = win_w(N_WIN)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [29:0]         i_mmio_addr,
   input  logic [31:0]         i_mmio_data,
   input  logic [3:0]          i_mmio_mask,
   input  logic                i_mmio_wren,
   input  logic [N_WIN-1:0]    i_win_en,
   input  logic [N_WIN*30-1:0] i_win_lo,
   input  logic [N_WIN*30-1:0] i_win_hi,
   output logic                o_trace_valid,
   input  logic                i_trace_ready,
   output logic [TS_W-1:0]     o_trace_ts,
   output logic [29:0]         o_trace_addr,
   output logic [31:0]         o_trace_data,
   output logic [3:0]          o_trace_mask,
   output logic [WIN_W-1:0]    o_trace_win,
   output logic [DROP_W-1:0]   o_drop_cnt,
   output logic                o_halt,
   output logic [31:0]         o_halt_code,
   output logic                o_timeout
);
   localparam int ENTRY_W = entry_w(TS_W, WIN_W);
   logic [TS_W-1:0]    r_ts;
   logic [31:0]        r_code;
   logic [DROP_W-1:0]  r_drop;
   logic               r_halt, r_timeout;
   logic               w_hit, w_push, w_pop, w_drop, w_full, w_halt_wr, w_to_hit;
   logic [WIN_W-1:0]   w_win;
   logic [ENTRY_W-1:0] w_head;
   // descending scan so the lowest matching window is the last assignment
   always_comb begin
      w_hit = 1'b0;
      w_win = '0;
      for (int k = N_WIN - 1; k >= 0; k--)
         if (i_win_en[k] && i_win_lo[30*k +: 30] <= i_mmio_addr && i_mmio_addr <= i_win_hi[30*k +: 30]) begin
            w_hit = 1'b1;
            w_win = WIN_W'(k);
         end
   end
   assign w_push    = i_mmio_wren && w_hit && !r_halt && !r_timeout;
   assign w_pop     = o_trace_valid && i_trace_ready;
   assign w_drop    = w_push && w_full && !w_pop;
   assign w_halt_wr = i_mmio_wren && (i_mmio_addr == HALT_ADDR);
   // the flag rises on the edge that carries the timestamp to TIMEOUT_CYC-1
   assign w_to_hit  = (TIMEOUT_CYC == 0) ? 1'b0 :
                      (TIMEOUT_CYC == 1) ? 1'b1 : (r_ts == TS_W'(TIMEOUT_CYC - 2));
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ts      <= '0;
         r_code    <= '0;
         r_drop    <= '0;
         r_halt    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_ts <= r_ts + 1'b1;
         if (w_halt_wr && !r_halt) begin
            r_halt <= 1'b1;
            r_code <= i_mmio_data;
         end
         if (w_to_hit) r_timeout <= 1'b1;
         if (w_drop && !(&r_drop)) r_drop <= r_drop + 1'b1;
      end
   end
   mmio_trace_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_push (w_push),
      .i_pop  (w_pop),
      .i_data ({r_ts, i_mmio_addr, i_mmio_data, i_mmio_mask, w_win}),
      .o_valid(o_trace_valid),
      .o_full (w_full),
      .o_data (w_head)
   );
   assign {o_trace_ts, o_trace_addr, o_trace_data, o_trace_mask, o_trace_win} = w_head;
   assign o_drop_cnt  = r_drop;
   assign o_halt      = r_halt;
   assign o_halt_code = r_code;
   assign o_timeout   = r_timeout;
endmodule

// File: tb/tb_mmio_trace_monitor.sv
// tb_mmio_trace_monitor: directed checks of the tracer (small FIFO instance plus a short-timeout instance)
module tb_mmio_trace_monitor;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [29:0] addr;
   logic [31:0] data;
   logic [3:0]  mask;
   logic        wren, ready;
   logic [1:0]  win_en;
   logic [59:0] win_lo, win_hi;
   logic        d_valid, d_halt, d_to;
   logic [31:0] d_ts, d_data, d_code;
   logic [29:0] d_addr;
   logic [3:0]  d_mask;
   logic [0:0]  d_win;
   logic [1:0]  d_drop;
   logic        t_valid, t_halt, t_to;
   logic [31:0] t_ts, t_data, t_code;
   logic [29:0] t_addr;
   logic [3:0]  t_mask;
   logic [0:0]  t_win;
   logic [15:0] t_drop;
   int          n_vec = 0;
   int          n_err = 0;
   localparam logic [29:0] HALT = 30'h3FFFFFFF;

   always #5 clk = ~clk;

   mmio_trace_monitor #(.DEPTH(4), .DROP_W(2), .TIMEOUT_CYC(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .i_mmio_addr(addr), .i_mmio_data(data), .i_mmio_mask(mask),
      .i_mmio_wren(wren), .i_win_en(win_en), .i_win_lo(win_lo), .i_win_hi(win_hi),
      .o_trace_valid(d_valid), .i_trace_ready(ready), .o_trace_ts(d_ts), .o_trace_addr(d_addr),
      .o_trace_data(d_data), .o_trace_mask(d_mask), .o_trace_win(d_win), .o_drop_cnt(d_drop),
      .o_halt(d_halt), .o_halt_code(d_code), .o_timeout(d_to));

   mmio_trace_monitor #(.TIMEOUT_CYC(20)) u_to (
      .clk(clk), .rst_n(rst_n), .i_mmio_addr(addr), .i_mmio_data(data), .i_mmio_mask(mask),
      .i_mmio_wren(wren), .i_win_en(win_en), .i_win_lo(win_lo), .i_win_hi(win_hi),
      .o_trace_valid(t_valid), .i_trace_ready(ready), .o_trace_ts(t_ts), .o_trace_addr(t_addr),
      .o_trace_data(t_data), .o_trace_mask(t_mask), .o_trace_win(t_win), .o_drop_cnt(t_drop),
      .o_halt(t_halt), .o_halt_code(t_code), .o_timeout(t_to));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      wren  = 1'b0;
      data  = 'x;
      mask  = 4'h0;
      ready = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
   endtask

   task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
      addr = a;
      data = d;
      mask = m;
      wren = 1'b1;
      tick();
      wren = 1'b0;
      data = 'x;
   endtask

   task automatic test_reset();
      win_en = 2'b11;
      win_lo = {30'h0, 30'h0};
      win_hi = {30'h3FFFFFFF, 30'h3FFFFFFF};
      addr   = 30'h0;
      do_reset();
      n_vec++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", d_valid); end
      n_vec++; if (d_ts !== 32'h0 || d_addr !== 30'h0 || d_data !== 32'h0 || d_mask !== 4'h0 || d_win !== 1'b0)
         begin n_err++; $display("FAIL rst_head: got ts=%h addr=%h data=%h mask=%h win=%h want all 0", d_ts, d_addr, d_data, d_mask, d_win); end
      n_vec++; if (d_drop !== 2'd0 || d_halt !== 1'b0 || d_code !== 32'h0 || d_to !== 1'b0)
         begin n_err++; $display("FAIL rst_flags: got drop=%h halt=%b code=%h to=%b want 0", d_drop, d_halt, d_code, d_to); end
   endtask

   task automatic test_single();
      win_en = 2'b01;
      win_lo = {30'h0, 30'h100};
      win_hi = {30'h0, 30'h1FF};
      do_reset();
      ready = 1'b1;
      repeat (5) tick();
      addr = 30'h140; data = 32'hDEADBEEF; mask = 4'hF; wren = 1'b1;
      n_vec++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL single_early: valid got %b want 0", d_valid); end
      tick();
      wren = 1'b0; data = 'x;
      n_vec++; if (d_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", d_valid); end
      n_vec++; if (d_ts !== 32'd5) begin n_err++; $display("FAIL single_ts: got %0d want 5", d_ts); end
      n_vec++; if (d_addr !== 30'h140 || d_data !== 32'hDEADBEEF || d_mask !== 4'hF || d_win !== 1'b0)
         begin n_err++; $display("FAIL single_entry: got addr=%h data=%h mask=%h win=%h want 140 deadbeef f 0", d_addr, d_data, d_mask, d_win); end
      tick();
      n_vec++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL single_pop: valid got %b want 0", d_valid); end
      ready = 1'b0;
   endtask

   task automatic test_windows();
      win_en = 2'b11;
      win_lo = {30'h080, 30'h000};
      win_hi = {30'h17F, 30'h0FF};
      do_reset();
      wr(30'h0A0, 32'h1, 4'hF);
      wr(30'h120, 32'h2, 4'h3);
      wr(30'h200, 32'h3, 4'hF);
      n_vec++; if (d_valid !== 1'b1 || d_addr !== 30'h0A0 || d_win !== 1'b0 || d_ts !== 32'd0)
         begin n_err++; $display("FAIL win_overlap: got v=%b addr=%h win=%h ts=%0d want 1 0a0 0 0", d_valid, d_addr, d_win, d_ts); end
      ready = 1'b1;
      tick();
      n_vec++; if (d_valid !== 1'b1 || d_addr !== 30'h120 || d_win !== 1'b1 || d_ts !== 32'd1 || d_mask !== 4'h3)
         begin n_err++; $display("FAIL win_second: got v=%b addr=%h win=%h ts=%0d mask=%h want 1 120 1 1 3", d_valid, d_addr, d_win, d_ts, d_mask); end
      tick();
      n_vec++; if (d_valid !== 1'b0 || d_drop !== 2'd0)
         begin n_err++; $display("FAIL win_nomatch: got v=%b drop=%0d want 0 0", d_valid, d_drop); end
      ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [29:0] exp_q [4] = '{30'h101, 30'h102, 30'h103, 30'h110};
      win_en = 2'b01;
      win_lo = {30'h0, 30'h100};
      win_hi = {30'h0, 30'h1FF};
      do_reset();
      for (int i = 0; i < 6; i++) wr(30'h100 + 30'(i), 32'(i), 4'hF);
      n_vec++; if (d_drop !== 2'd2) begin n_err++; $display("FAIL full_drop: got %0d want 2", d_drop); end
      n_vec++; if (d_addr !== 30'h100 || d_data !== 32'h0) begin n_err++; $display("FAIL full_head: got addr=%h data=%h want 100 0", d_addr, d_data); end
      ready = 1'b1;
      wr(30'h110, 32'h77, 4'hF);
      n_vec++; if (d_drop !== 2'd2 || d_addr !== 30'h101)
         begin n_err++; $display("FAIL full_pushpop: got drop=%0d head=%h want 2 101", d_drop, d_addr); end
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (d_valid !== 1'b1 || d_addr !== exp_q[i])
            begin n_err++; $display("FAIL drain_%0d: got v=%b addr=%h want 1 %h", i, d_valid, d_addr, exp_q[i]); end
         tick();
      end
      n_vec++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: valid got %b want 0", d_valid); end
      ready = 1'b0;
   endtask

   task automatic test_drop_sat();
      win_en = 2'b01;
      do_reset();
      for (int i = 0; i < 4; i++) wr(30'h100 + 30'(i), 32'(i), 4'hF);
      n_vec++; if (d_drop !== 2'd0) begin n_err++; $display("FAIL sat_none: got %0d want 0", d_drop); end
      for (int i = 4; i < 7; i++) wr(30'h100 + 30'(i), 32'(i), 4'hF);
      n_vec++; if (d_drop !== 2'd3) begin n_err++; $display("FAIL sat_three: got %0d want 3", d_drop); end
      for (int i = 7; i < 9; i++) wr(30'h100 + 30'(i), 32'(i), 4'hF);
      n_vec++; if (d_drop !== 2'd3 || d_addr !== 30'h100)
         begin n_err++; $display("FAIL sat_hold: got drop=%0d head=%h want 3 100", d_drop, d_addr); end
   endtask

   task automatic test_halt();
      win_en = 2'b11;
      win_lo = {HALT, 30'h100};
      win_hi = {HALT, 30'h1FF};
      do_reset();
      wr(30'h100, 32'h11, 4'hF);
      addr = HALT; data = 32'h0000002A; mask = 4'h1; wren = 1'b1;
      n_vec++; if (d_halt !== 1'b0) begin n_err++; $display("FAIL halt_early: got %b want 0", d_halt); end
      tick();
      wren = 1'b0; data = 'x;
      n_vec++; if (d_halt !== 1'b1 || d_code !== 32'h2A) begin n_err++; $display("FAIL halt_set: got halt=%b code=%h want 1 2a", d_halt, d_code); end
      wr(30'h101, 32'h22, 4'hF);
      wr(30'h102, 32'h33, 4'hF);
      wr(30'h103, 32'h44, 4'hF);
      n_vec++; if (d_drop !== 2'd0) begin n_err++; $display("FAIL halt_nodrop: got %0d want 0", d_drop); end
      ready = 1'b1;
      n_vec++; if (d_valid !== 1'b1 || d_addr !== 30'h100) begin n_err++; $display("FAIL halt_head0: got v=%b addr=%h want 1 100", d_valid, d_addr); end
      tick();
      n_vec++; if (d_valid !== 1'b1 || d_addr !== HALT || d_win !== 1'b1 || d_data !== 32'h2A || d_mask !== 4'h1)
         begin n_err++; $display("FAIL halt_traced: got v=%b addr=%h win=%h data=%h mask=%h want 1 3fffffff 1 2a 1", d_valid, d_addr, d_win, d_data, d_mask); end
      tick();
      n_vec++; if (d_valid !== 1'b0 || d_halt !== 1'b1) begin n_err++; $display("FAIL halt_frozen: got v=%b halt=%b want 0 1", d_valid, d_halt); end
      ready = 1'b0;
   endtask

   task automatic test_timeout();
      win_en = 2'b01;
      win_lo = {30'h0, 30'h100};
      win_hi = {30'h0, 30'h1FF};
      do_reset();
      repeat (18) tick();
      n_vec++; if (t_to !== 1'b0) begin n_err++; $display("FAIL to_early: got %b want 0", t_to); end
      wr(30'h100, 32'hA, 4'hF);
      n_vec++; if (t_to !== 1'b1 || d_to !== 1'b0) begin n_err++; $display("FAIL to_rise: got to=%b never=%b want 1 0", t_to, d_to); end
      wr(30'h101, 32'hB, 4'hF);
      ready = 1'b1;
      n_vec++; if (t_valid !== 1'b1 || t_ts !== 32'd18 || t_addr !== 30'h100)
         begin n_err++; $display("FAIL to_head: got v=%b ts=%0d addr=%h want 1 18 100", t_valid, t_ts, t_addr); end
      tick();
      ready = 1'b0;
      n_vec++; if (t_valid !== 1'b0 || d_valid !== 1'b1)
         begin n_err++; $display("FAIL to_frozen: got to_v=%b dut_v=%b want 0 1", t_valid, d_valid); end
      rst_n = 1'b0;
      tick();
      n_vec++; if (t_valid !== 1'b0 || t_to !== 1'b0 || t_ts !== 32'h0 || t_addr !== 30'h0 || t_data !== 32'h0 ||
                   t_mask !== 4'h0 || t_win !== 1'b0 || t_drop !== 16'h0 || t_halt !== 1'b0 || t_code !== 32'h0)
         begin n_err++; $display("FAIL to_reset: got v=%b to=%b ts=%h addr=%h data=%h mask=%h win=%h drop=%h halt=%b code=%h want all 0",
                                 t_valid, t_to, t_ts, t_addr, t_data, t_mask, t_win, t_drop, t_halt, t_code); end
      n_vec++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL reset_discard: valid got %b want 0", d_valid); end
      do_reset();
      wr(30'h105, 32'hC, 4'hF);
      n_vec++; if (t_valid !== 1'b1 || t_ts !== 32'd0 || t_addr !== 30'h105 || t_to !== 1'b0)
         begin n_err++; $display("FAIL ts_restart: got v=%b ts=%0d addr=%h to=%b want 1 0 105 0", t_valid, t_ts, t_addr, t_to); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_windows();
      test_back_to_back();
      test_drop_sat();
      test_halt();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
